// File: rtl/wb_bus_pkg.sv
// Shared definitions for the multi-master Wishbone bus: FSM encoding,
// address decode field and counter sizing.
package wb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } bus_state_t;

    localparam int ADR_W   = 32;
    localparam int SLV_MSB = 31;
    localparam int SLV_LSB = 28;
    localparam int SLV_W   = SLV_MSB - SLV_LSB + 1;
    localparam int CNT_W   = 16;

    // Index width that stays legal for a single-master build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational bus arbiter: round-robin from last_owner+1, or fixed
// priority with the lowest requesting index winning.
module wb_rr_arbiter
    import wb_bus_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = idx_w(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last_owner,
    input  logic          mode,
    output logic [NM-1:0] grant
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            if (mode) idx = IW'(i - 1);
            else      idx = IW'((int'(last_owner) + i) % NM);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// Shared Wishbone bus: NM masters arbitrated onto NS slaves decoded from
// adr[31:28], with bus lock, decode-miss errors and a response timeout.
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int NM       = 2,
    parameter int NS       = 4,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*ADR_W-1:0]  m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    output logic                 s_we_o,
    output logic [ADR_W-1:0]     s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i
);

    localparam int IW = idx_w(NM);
    localparam int SW = DW / 8;

    bus_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, last_q, last_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [NM-1:0]    grant;
    logic [IW-1:0]    win_idx;

    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DW-1:0]    own_dat;
    logic [SW-1:0]    own_sel;
    logic [SLV_W-1:0] slv_idx;
    logic             miss;
    logic             sel_ack, sel_err;
    logic [DW-1:0]    sel_dat;

    wb_rr_arbiter #(.NM(NM), .IW(IW)) u_arb (
        .req        (m_cyc_i),
        .last_owner (last_q),
        .mode       (ARB_MODE != 0),
        .grant      (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NM; i++)
            if (grant[i]) win_idx = IW'(i);
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int i = 0; i < NM; i++) begin
            if (owner_q == IW'(i)) begin
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
                own_we  = m_we_i[i];
                own_adr = m_adr_i[i*ADR_W +: ADR_W];
                own_dat = m_dat_i[i*DW +: DW];
                own_sel = m_sel_i[i*SW +: SW];
            end
        end
    end

    assign slv_idx = own_adr[SLV_MSB:SLV_LSB];
    assign miss    = (int'(slv_idx) >= NS);

    // A decode miss matches no slave below, so the response is all zero.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int j = 0; j < NS; j++) begin
            if (slv_idx == SLV_W'(j)) begin
                sel_ack = s_ack_i[j];
                sel_err = s_err_i[j];
                sel_dat = s_dat_i[j*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    owner_d = win_idx;
                    state_d = BUSY;
                    tmo_d   = '0;
                end
            end
            BUSY: begin
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                s_sel_o = own_sel;
                for (int j = 0; j < NS; j++) begin
                    if (slv_idx == SLV_W'(j)) begin
                        s_cyc_o[j] = own_cyc;
                        s_stb_o[j] = own_cyc & own_stb;
                    end
                end
                // Responses pass even if the owner drops cyc in the same cycle.
                for (int i = 0; i < NM; i++) begin
                    if (owner_q == IW'(i)) begin
                        m_ack_o[i]         = sel_ack;
                        m_err_o[i]         = sel_err;
                        m_dat_o[i*DW +: DW] = sel_dat;
                    end
                end
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    tmo_d   = '0;
                end else if (own_stb && miss) begin
                    state_d = ERR;
                    tmo_d   = '0;
                end else if (!own_stb || sel_ack || sel_err) begin
                    tmo_d = '0;
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ERR: begin
                for (int i = 0; i < NM; i++)
                    if (owner_q == IW'(i)) m_err_o[i] = 1'b1;
                state_d = BUSY;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NM - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Scoreboard bench for wb_shared_bus: a round-robin instance with modelled
// slaves and a fixed-priority instance with always-acking slaves.
module tb_wb_shared_bus;

    typedef struct {
        int          m;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdat;
        bit          chk_wr;
        logic [31:0] wdat;
        bit          nostb;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   fails = 0;

    logic [1:0]  t_cyc[2], t_stb[2], t_we[2];
    logic [63:0] t_adr[2], t_dat[2];
    logic [7:0]  t_sel[2];
    logic [63:0] o_mdat[2];
    logic [1:0]  o_ack[2], o_err[2];

    logic [3:0]   s_cyc, s_stb, f_scyc, f_sstb;
    logic         s_we, f_swe;
    logic [31:0]  s_adr, s_dat, f_sadr, f_sdat;
    logic [3:0]   s_sel, f_ssel;
    logic [3:0]   ack_q = '0, err_q = '0;
    logic [127:0] s_rdat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    logic [127:0] f_rdat = {4{32'hF0F0_0000}};
    logic [3:0]   f_serr = '0;

    exp_t sb_q[$];
    int   fp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slaves 0/1 ack one cycle after strobe, slave 2 never answers, slave 3 errors.
    always @(posedge clk) begin
        ack_q <= s_stb & ~ack_q & 4'b0011;
        err_q <= s_stb & ~err_q & 4'b1000;
    end

    wb_shared_bus #(.NM(2), .NS(4), .DW(32), .ARB_MODE(0), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(t_cyc[0]), .m_stb_i(t_stb[0]), .m_we_i(t_we[0]),
        .m_adr_i(t_adr[0]), .m_dat_i(t_dat[0]), .m_sel_i(t_sel[0]),
        .m_dat_o(o_mdat[0]), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_dat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(ack_q), .s_err_i(err_q)
    );

    wb_shared_bus #(.NM(2), .NS(4), .DW(32), .ARB_MODE(1), .TIMEOUT(8)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(t_cyc[1]), .m_stb_i(t_stb[1]), .m_we_i(t_we[1]),
        .m_adr_i(t_adr[1]), .m_dat_i(t_dat[1]), .m_sel_i(t_sel[1]),
        .m_dat_o(o_mdat[1]), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]),
        .s_cyc_o(f_scyc), .s_stb_o(f_sstb), .s_we_o(f_swe), .s_adr_o(f_sadr),
        .s_dat_o(f_sdat), .s_sel_o(f_ssel),
        .s_dat_i(f_rdat), .s_ack_i(f_sstb), .s_err_i(f_serr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int m, input bit err, input bit chk_rd,
                                input logic [31:0] rdat, input bit chk_wr,
                                input logic [31:0] wdat, input bit nostb, input int cyc);
        exp_t e;
        e.m = m; e.err = err; e.chk_rd = chk_rd; e.rdat = rdat;
        e.chk_wr = chk_wr; e.wdat = wdat; e.nostb = nostb; e.cyc = cyc;
        return e;
    endfunction

    // One master transaction; e.cyc is an offset from the cycle cyc rises.
    task automatic run_txn(input int inst, input int m, input logic we,
                           input logic [31:0] adr, input logic [31:0] wdat,
                           input int stb_delay, input int drop_after,
                           input exp_t e, input bit push);
        int raise_cyc;
        bit got;
        @(posedge clk); #1;
        t_cyc[inst][m] = 1'b1;
        t_we[inst][m]  = we;
        t_adr[inst][m*32 +: 32] = adr;
        t_dat[inst][m*32 +: 32] = wdat;
        t_sel[inst][m*4 +: 4]   = 4'hF;
        t_stb[inst][m] = (stb_delay == 0);
        raise_cyc = cyc_cnt;
        if (push) begin
            if (e.cyc >= 0) e.cyc = e.cyc + raise_cyc;
            sb_q.push_back(e);
        end
        if (stb_delay > 0) begin
            repeat (stb_delay) @(posedge clk);
            #1 t_stb[inst][m] = 1'b1;
        end
        if (drop_after > 0) begin
            repeat (drop_after) @(posedge clk);
            #1;
        end else begin
            got = 1'b0;
            for (int k = 0; k < 64 && !got; k++) begin
                @(negedge clk);
                got = o_ack[inst][m] | o_err[inst][m];
            end
            if (!got) begin
                checks++;
                fails++;
                $display("FAIL resp_timeout inst=%0d master=%0d actual=none required=ack_or_err", inst, m);
            end
            @(posedge clk); #1;
        end
        t_cyc[inst][m] = 1'b0;
        t_stb[inst][m] = 1'b0;
        t_we[inst][m]  = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (o_ack[0][i] | o_err[0][i]) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp master=%0d actual=ack%b_err%b required=none", i, o_ack[0][i], o_err[0][i]);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_master", 64'(i), 64'(e.m));
                    chk("resp_is_err", 64'(o_err[0][i]), 64'(e.err));
                    if (e.chk_rd) chk("read_data", 64'(o_mdat[0][i*32 +: 32]), 64'(e.rdat));
                    if (e.chk_wr) chk("write_data", {31'd0, s_we, s_dat}, {31'd0, 1'b1, e.wdat});
                    if (e.nostb)  chk("miss_no_stb", 64'(s_stb), 64'd0);
                    if (e.cyc >= 0) chk("resp_cycle", 64'(cyc_cnt), 64'(e.cyc));
                    chk("nonowner_dat", 64'(o_mdat[0][(1-i)*32 +: 32]), 64'd0);
                    chk("nonowner_resp", 64'(o_ack[0][1-i] | o_err[0][1-i]), 64'd0);
                end
            end
            if (o_ack[1][i]) begin
                if (fp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL fp_unexpected master=%0d actual=ack required=none", i);
                end else begin
                    chk("fp_grant_order", 64'(i), 64'(fp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t nul;
        nul = mk(0, 0, 0, 0, 0, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            t_cyc[k] = '0; t_stb[k] = '0; t_we[k] = '0;
            t_adr[k] = '0; t_dat[k] = '0; t_sel[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_m_ack", 64'(o_ack[0]), 64'd0);
        chk("rst_m_err", 64'(o_err[0]), 64'd0);
        chk("rst_m_dat", o_mdat[0], 64'd0);
        chk("rst_s_adr", 64'(s_adr), 64'd0);
        rst = 1'b0;

        run_txn(0, 0, 1'b0, 32'h0000_0010, 32'h0, 0, 0, mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 2), 1'b1);
        run_txn(0, 1, 1'b1, 32'h1000_0004, 32'hCAFE_0001, 0, 0, mk(1, 0, 0, 0, 1, 32'hCAFE_0001, 0, 2), 1'b1);
        run_txn(0, 1, 1'b1, 32'h5000_0000, 32'h1234_5678, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 2), 1'b1);
        run_txn(0, 0, 1'b0, 32'h3000_0000, 32'h0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 2), 1'b1);

        // Owner releases cyc in the very cycle the slave acks.
        run_txn(0, 0, 1'b0, 32'h0000_0020, 32'h0, 0, 2, mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 2), 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("early_drop_no_err", 64'(o_err[0]), 64'd0);

        run_txn(0, 0, 1'b0, 32'h2000_0000, 32'h0, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 9), 1'b1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, -1));
        sb_q.push_back(mk(1, 0, 1, 32'h1111_1111, 0, 0, 0, -1));
        sb_q.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, -1));
        fork
            begin
                run_txn(0, 0, 1'b0, 32'h0000_0000, 32'h0, 0, 0, nul, 1'b0);
                run_txn(0, 0, 1'b0, 32'h0000_0004, 32'h0, 0, 0, nul, 1'b0);
            end
            run_txn(0, 1, 1'b0, 32'h1000_0000, 32'h0, 0, 0, nul, 1'b0);
        join

        @(posedge clk); #1;
        t_cyc[0][0] = 1'b1; t_stb[0][0] = 1'b1; t_we[0][0] = 1'b0;
        t_adr[0][31:0] = 32'h1000_0008;
        @(posedge clk); #1;
        chk("mid_xfer_s_cyc", 64'(s_cyc), 64'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        t_cyc[0][0] = 1'b0; t_stb[0][0] = 1'b0;
        chk("mid_rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("mid_rst_m_ack", 64'(o_ack[0]), 64'd0);
        chk("mid_rst_m_err", 64'(o_err[0]), 64'd0);
        sb_q.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, -1));
        sb_q.push_back(mk(1, 0, 1, 32'h1111_1111, 0, 0, 0, -1));
        fork
            run_txn(0, 0, 1'b0, 32'h0000_0000, 32'h0, 0, 0, nul, 1'b0);
            run_txn(0, 1, 1'b0, 32'h1000_0000, 32'h0, 0, 0, nul, 1'b0);
        join

        fp_q.push_back(0); fp_q.push_back(0); fp_q.push_back(0); fp_q.push_back(1);
        fork
            begin
                for (int r = 0; r < 3; r++)
                    run_txn(1, 0, 1'b0, 32'h0000_0000, 32'h0, 0, 0, nul, 1'b0);
            end
            run_txn(1, 1, 1'b0, 32'h0000_0000, 32'h0, 0, 0, nul, 1'b0);
        join

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("fp_drained", 64'(fp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
